// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between execute stage and the M-extension unit
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] regDataS1;
    logic [XLEN-1:0] regDataS2;
    logic [XLEN-1:0] data_ALU_MEM;
    logic [XLEN-1:0] data_MEM_WB;
    logic [1:0]      select1;
    logic [1:0]      select2;
    logic            flush;
    logic            busy;
    logic            out_valid;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, regDataS1, regDataS2, data_ALU_MEM, data_MEM_WB,
               select1, select2, flush,
        input  in_ready, busy, out_valid, result
    );

    modport slave (
        input  in_valid, op, regDataS1, regDataS2, data_ALU_MEM, data_MEM_WB,
               select1, select2, flush,
        output in_ready, busy, out_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 MUL/DIV/REM unit with operand forwarding and flush
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [1:0] FROM_REG     = 2'd0;
    localparam logic [1:0] FROM_ALU_MEM = 2'd1;
    localparam logic [1:0] FROM_MEM_WB  = 2'd2;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_r;
    logic              neg;
    logic [XLEN-1:0]   opnd_b;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic              out_valid_r;
    logic [XLEN-1:0]   result_r;

    function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel,
                                            input logic [XLEN-1:0] reg_v,
                                            input logic [XLEN-1:0] alu_v,
                                            input logic [XLEN-1:0] wb_v);
        case (sel)
            FROM_ALU_MEM: fwd = alu_v;
            FROM_MEM_WB:  fwd = wb_v;
            FROM_REG:     fwd = reg_v;
            default:      fwd = reg_v;
        endcase
    endfunction

    logic [XLEN-1:0] a, b, mag_a, mag_b, fast_res;
    logic            sa, sb, neg_in, div_zero, div_ovf;

    always_comb begin
        a  = fwd(bus.select1, bus.regDataS1, bus.data_ALU_MEM, bus.data_MEM_WB);
        b  = fwd(bus.select2, bus.regDataS2, bus.data_ALU_MEM, bus.data_MEM_WB);
        sa = a[XLEN-1] && (bus.op == 3'd1 || bus.op == 3'd2 || bus.op == 3'd4 || bus.op == 3'd6);
        sb = b[XLEN-1] && (bus.op == 3'd1 || bus.op == 3'd4 || bus.op == 3'd6);
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
        // REM takes the dividend's sign; every other op the product/quotient sign
        neg_in   = (bus.op == 3'd6) ? sa : (sa ^ sb);
        div_zero = bus.op[2] && (b == '0);
        div_ovf  = bus.op[2] && !bus.op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        if (div_zero)
            fast_res = bus.op[1] ? a : '1;
        else
            fast_res = bus.op[1] ? '0 : a;
    end

    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic [2*XLEN-1:0] mul_next, prod_fin;
    logic [XLEN-1:0]   quo_next, rem_next, fin_res;
    logic              div_take;

    always_comb begin
        // shift-right accumulator: multiplier sits in the low half and drains out
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_b} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {rem, acc[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd_b};
        div_take  = !div_trial[XLEN];
        rem_next  = div_take ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_next  = {acc[XLEN-2:0], div_take};
        prod_fin  = neg ? -mul_next : mul_next;
        case (op_r)
            3'd0:                fin_res = prod_fin[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fin_res = prod_fin[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fin_res = neg ? -quo_next : quo_next;
            default:             fin_res = neg ? -rem_next : rem_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_r        <= '0;
            neg         <= 1'b0;
            opnd_b      <= '0;
            acc         <= '0;
            rem         <= '0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
        end else begin
            out_valid_r <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (bus.in_valid) begin
                        op_r   <= bus.op;
                        neg    <= neg_in;
                        opnd_b <= mag_b;
                        acc    <= {{XLEN{1'b0}}, mag_a};
                        rem    <= '0;
                        cnt    <= CNT_W'(XLEN - 1);
                        if (div_zero || div_ovf) begin
                            result_r    <= fast_res;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        if (op_r[2]) begin
                            acc[XLEN-1:0] <= quo_next;
                            rem           <= rem_next;
                        end else begin
                            acc <= mul_next;
                        end
                        if (cnt == '0) begin
                            result_r    <= fin_res;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
    localparam int XLEN     = 32;
    localparam int LAT_CALC = XLEN + 1;
    localparam int LAT_FAST = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rv,
                                         input logic [31:0] av, input logic [31:0] wv);
        return (sel == 2'd1) ? av : (sel == 2'd2) ? wv : rv;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] alu, input logic [31:0] wb,
                         input logic [1:0] s1, input logic [1:0] s2, output int waited);
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1; waited++;
        end
        if (waited >= 100) begin
            checks++; errors++;
            $display("FAIL issue_ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.op = op; bus.regDataS1 = r1; bus.regDataS2 = r2;
        bus.data_ALU_MEM = alu; bus.data_MEM_WB = wb;
        bus.select1 = s1; bus.select2 = s2; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom); bus.regDataS1 = $urandom; bus.regDataS2 = $urandom;
        bus.data_ALU_MEM = $urandom; bus.data_MEM_WB = $urandom;
        bus.select1 = 2'($urandom); bus.select2 = 2'($urandom);
    endtask

    task automatic wait_done(output logic [31:0] res, output int ov_edge, output int ov_cnt,
                             output int busy_cnt, output logic rdy_at_ov);
        int edges = 1;
        res = 'x; ov_edge = -1; ov_cnt = 0; busy_cnt = 0; rdy_at_ov = 1'bx;
        while (edges < 200) begin
            if (bus.out_valid === 1'b1) begin
                if (ov_cnt == 0) begin
                    res = bus.result; ov_edge = edges; rdy_at_ov = bus.in_ready;
                end
                ov_cnt++;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            else break;
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.flush = 0; bus.op = 0; bus.select1 = 0; bus.select2 = 0;
        bus.regDataS1 = 0; bus.regDataS2 = 0; bus.data_ALU_MEM = 0; bus.data_MEM_WB = 0;
        #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held: got %b want 0", bus.in_ready); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_released: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_mul_basic();
        logic [31:0] res; int ov_edge, ov_cnt, busy_cnt, w; logic rdy;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'h0, 2'd0, 2'd0, w);
        wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", res); end
        checks++; if (ov_edge != LAT_CALC) begin errors++; $display("FAIL mul_latency: got %0d want %0d", ov_edge, LAT_CALC); end
        checks++; if (ov_cnt != 1) begin errors++; $display("FAIL mul_out_valid_width: got %0d want 1", ov_cnt); end
        checks++; if (busy_cnt != LAT_CALC) begin errors++; $display("FAIL mul_busy_cycles: got %0d want %0d", busy_cnt, LAT_CALC); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mul_ready_in_done: got %b want 0", rdy); end
        checks++; if (bus.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_held: got %h want ffffffeb", bus.result); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mul_ready_after: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_mulh_variants();
        logic [2:0] ops [3]; logic [31:0] va [3]; logic [31:0] vb [3]; logic [31:0] ve [3];
        logic [31:0] res; int ov_edge, ov_cnt, busy_cnt, w; logic rdy;
        ops = '{3'd1, 3'd3, 3'd2};
        va  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vb  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ve  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], va[i], vb[i], 32'h0, 32'h0, 2'd0, 2'd0, w);
            wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
            checks++; if (res !== ve[i]) begin errors++; $display("FAIL mulh_op%0d_result: got %h want %h", ops[i], res, ve[i]); end
            checks++; if (ov_edge != LAT_CALC) begin errors++; $display("FAIL mulh_op%0d_latency: got %0d want %0d", ops[i], ov_edge, LAT_CALC); end
        end
    endtask

    task automatic test_div_vectors();
        logic [2:0] ops [4]; logic [31:0] va [4]; logic [31:0] vb [4]; logic [31:0] ve [4];
        logic [31:0] res; int ov_edge, ov_cnt, busy_cnt, w; logic rdy;
        ops = '{3'd4, 3'd6, 3'd5, 3'd7};
        va  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        vb  = '{32'd2, 32'd2, 32'd7, 32'd7};
        ve  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], va[i], vb[i], 32'h0, 32'h0, 2'd0, 2'd0, w);
            wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
            checks++; if (res !== ve[i]) begin errors++; $display("FAIL div_op%0d_result: got %h want %h", ops[i], res, ve[i]); end
            checks++; if (ov_edge != LAT_CALC) begin errors++; $display("FAIL div_op%0d_latency: got %0d want %0d", ops[i], ov_edge, LAT_CALC); end
        end
    endtask

    task automatic test_fast_path();
        logic [2:0] ops [4]; logic [31:0] va [4]; logic [31:0] vb [4]; logic [31:0] ve [4];
        logic [31:0] res; int ov_edge, ov_cnt, busy_cnt, w; logic rdy;
        ops = '{3'd4, 3'd7, 3'd4, 3'd6};
        va  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        vb  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ve  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], va[i], vb[i], 32'h0, 32'h0, 2'd0, 2'd0, w);
            wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
            checks++; if (res !== ve[i]) begin errors++; $display("FAIL fast_%0d_result: got %h want %h", i, res, ve[i]); end
            checks++; if (ov_edge != LAT_FAST) begin errors++; $display("FAIL fast_%0d_latency: got %0d want %0d", i, ov_edge, LAT_FAST); end
            checks++; if (busy_cnt != 1 || ov_cnt != 1) begin errors++; $display("FAIL fast_%0d_cycles: busy %0d valid %0d want 1 1", i, busy_cnt, ov_cnt); end
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] res; int ov_edge, ov_cnt, busy_cnt, w; logic rdy;
        issue(3'd5, 32'd0, 32'd0, 32'd12, 32'd3, 2'd1, 2'd2, w);
        wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
        checks++; if (res !== 32'd4) begin errors++; $display("FAIL fwd_alu_wb: got %h want 4", res); end
        issue(3'd5, 32'd100, 32'd7, 32'd12, 32'd3, 2'd3, 2'd3, w);
        wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL fwd_code3_reg: got %h want e", res); end
        issue(3'd5, 32'd9, 32'd9, 32'd5, 32'd40, 2'd2, 2'd1, w);
        wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
        checks++; if (res !== 32'd8) begin errors++; $display("FAIL fwd_wb_alu: got %h want 8", res); end
    endtask

    task automatic test_random();
        logic [31:0] r1, r2, alu, wb, a, b, exp, res; logic [2:0] op; logic [1:0] s1, s2;
        int ov_edge, ov_cnt, busy_cnt, w, lat; logic rdy;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            r1  = $urandom; alu = $urandom; wb = $urandom;
            r2  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            s1  = 2'($urandom_range(0, 3)); s2 = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: begin s2 = 2'd0; r2 = 32'h0; end
                1: begin s1 = 2'd0; s2 = 2'd0; r1 = 32'h8000_0000; r2 = 32'hFFFF_FFFF; end
                default: ;
            endcase
            a = pick(s1, r1, alu, wb);
            b = pick(s2, r2, alu, wb);
            exp = model(op, a, b);
            lat = (op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                  ? LAT_FAST : LAT_CALC;
            issue(op, r1, r2, alu, wb, s1, s2, w);
            wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
            checks++; if (res !== exp) begin errors++; $display("FAIL rand_%0d_op%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp); end
            checks++; if (ov_edge != lat || ov_cnt != 1) begin errors++; $display("FAIL rand_%0d_timing: edge %0d cnt %0d want %0d 1", i, ov_edge, ov_cnt, lat); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res, prior; int ov_edge, ov_cnt, busy_cnt, w, seen; logic rdy;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 2'd0, 2'd0, w);
        wait_done(prior, ov_edge, ov_cnt, busy_cnt, rdy);
        checks++; if (prior !== 32'hFFFF_FFFE) begin errors++; $display("FAIL flush_prior: got %h want fffffffe", prior); end
        issue(3'd0, 32'h1234, 32'h5678, 32'h0, 32'h0, 2'd0, 2'd0, w);
        seen = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        if (bus.out_valid !== 1'b0) seen++;
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_valid: got %0d strobes want 0", seen); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle: busy %b want 0", bus.busy); end
        checks++; if (bus.result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL flush_result_kept: got %h want fffffffe", bus.result); end
        issue(3'd0, 32'd3, 32'd4, 32'h0, 32'h0, 2'd0, 2'd0, w);
        checks++; if (w != 0) begin errors++; $display("FAIL flush_next_accept: waited %0d want 0", w); end
        wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
        checks++; if (res !== 32'd12 || ov_edge != LAT_CALC) begin errors++; $display("FAIL flush_then_mul: got %h at %0d want c at %0d", res, ov_edge, LAT_CALC); end
        bus.op = 3'd0; bus.select1 = 2'd0; bus.select2 = 2'd0;
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept: busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res; int ov_edge, ov_cnt, busy_cnt, w; logic rdy;
        issue(3'd0, 32'h1234, 32'h5678, 32'h0, 32'h0, 2'd0, 2'd0, w);
        for (int k = 0; k < 9; k++) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags: busy %b valid %b ready %b want 0 0 0", bus.busy, bus.out_valid, bus.in_ready);
        end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", bus.result); end
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready); end
        issue(3'd0, 32'd3, 32'd4, 32'h0, 32'h0, 2'd0, 2'd0, w);
        wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL rst_mid_then_mul: got %h want c", res); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3]; logic [31:0] va [3]; logic [31:0] vb [3];
        logic [31:0] res, exp; int ov_edge, ov_cnt, busy_cnt, w; logic rdy;
        ops = '{3'd5, 3'd7, 3'd1};
        va  = '{32'd100, 32'd100, 32'hFFFF_0000};
        vb  = '{32'd7, 32'd0, 32'h0001_2345};
        for (int i = 0; i < 3; i++) begin
            exp = model(ops[i], va[i], vb[i]);
            issue(ops[i], va[i], vb[i], 32'h0, 32'h0, 2'd0, 2'd0, w);
            if (i > 0) begin
                checks++; if (w != 0) begin errors++; $display("FAIL b2b_%0d_accept_gap: waited %0d want 0", i, w); end
            end
            wait_done(res, ov_edge, ov_cnt, busy_cnt, rdy);
            checks++; if (res !== exp) begin errors++; $display("FAIL b2b_%0d_result: got %h want %h", i, res, exp); end
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_%0d_ready_in_done: got %b want 0", i, rdy); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_mulh_variants();
        test_div_vectors();
        test_fast_path();
        test_forwarding();
        test_random();
        test_flush();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
